// File: rtl/seq_shifter.sv
// Multi-cycle barrel-lite shifter: SLL/SRL/SRA/ROR performed at most STEP bits per clock,
// with a valid/ready request port, a valid/ready result port and a synchronous flush.
module seq_shifter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = 5,
  parameter int unsigned STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [SHW-1:0]  in_amt,
  input  logic [1:0]      in_mode,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int unsigned CW = SHW + 1;
  localparam logic [CW-1:0]  STEP_W = CW'(STEP);
  localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   work_q,  work_d;
  logic [SHW-1:0]    rem_q,   rem_d;
  logic [1:0]        mode_q,  mode_d;
  logic              sign_q,  sign_d;

  logic [SHW-1:0]    k_c;
  logic [2*XLEN-1:0] ext_c;
  logic [XLEN-1:0]   shifted_c;
  logic              accept_c;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
    end
  end

  // One step: k = min(STEP, rem); right shifts take the fill from the upper half of ext_c.
  // rem < XLEN, so the STEP branch is only taken when STEP itself fits in SHW bits.
  always_comb begin
    k_c = ({1'b0, rem_q} > STEP_W) ? STEP_K : rem_q;
    unique case (mode_q)
      M_SRA:   ext_c = {{XLEN{sign_q}}, work_q};
      M_ROR:   ext_c = {work_q, work_q};
      default: ext_c = {{XLEN{1'b0}}, work_q};
    endcase
    if (mode_q == M_SLL) begin
      shifted_c = work_q << k_c;
    end else begin
      shifted_c = XLEN'(ext_c >> k_c);
    end
  end

  assign accept_c = in_valid && in_ready;

  // Next-state logic; flush overrides accept and delivery
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    sign_d  = sign_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          work_d  = in_data;
          rem_d   = in_amt;
          mode_d  = in_mode;
          sign_d  = (in_mode == M_SRA) ? in_data[XLEN-1] : 1'b0;
          state_d = (in_amt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        work_d = shifted_c;
        rem_d  = rem_q - k_c;
        if (rem_q == k_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decode registered state; in_ready is held low while reset is applied
  assign in_ready  = rst_n && (state_q == S_IDLE) && !flush;
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_valid ? work_q : '0;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter (XLEN=32, STEP=4): vector table + random ops through a scoreboard,
// plus directed flush and reset sequences.
module tb_seq_shifter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;
  localparam int unsigned STEP = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_data;
  logic [SHW-1:0]  in_amt;
  logic [1:0]      in_mode;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            busy;

  seq_shifter #(.XLEN(XLEN), .SHW(SHW), .STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  amt;
    logic [1:0]  mode;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic [1:0] m);
    int unsigned sh;
    sh = int'(a);
    case (m)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return $unsigned($signed(d) >>> sh);
      default: return (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
    endcase
  endfunction

  // Full transaction: accept, scramble inputs and keep in_valid high while busy, wait for result
  task automatic do_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                       input logic [31:0] e, input int hold);
    exp_t x;
    exp_t got;
    int   cyc;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m; out_ready = 1'b0;
    #1 check("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    x.data = e;
    x.lat  = int'((32'(a) + STEP - 1) / STEP);
    sb.push_back(x);
    #1;
    check("busy_after_accept", 64'(busy), 64'd1);
    in_data = ~d; in_amt = ~a; in_mode = ~m;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      check("out_data_zero_in_run", 64'(out_data), 64'd0);
      check("in_ready_low_in_run", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    got = sb.pop_front();
    check("out_valid_rise", 64'(out_valid), 64'd1);
    check("latency", 64'(cyc), 64'(got.lat));
    check("result", 64'(out_data), 64'(got.data));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'(got.data));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("delivered_valid", 64'(out_valid), 64'd0);
    check("delivered_data", 64'(out_data), 64'd0);
    check("delivered_busy", 64'(busy), 64'd0);
    check("delivered_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[13];
    logic [31:0] rd;
    logic [4:0]  ra;
    logic [1:0]  rm;

    vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 0};
    vecs[1]  = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1};
    vecs[2]  = '{32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 0};
    vecs[3]  = '{32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 0};
    vecs[4]  = '{32'h1234_5678, 5'd8,  2'b11, 32'h7812_3456, 0};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 3};
    vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 0};
    vecs[7]  = '{32'h8000_0001, 5'd31, 2'b11, 32'h0000_0003, 2};
    vecs[8]  = '{32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 0};
    vecs[9]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 0};
    vecs[10] = '{32'hFFFF_FFFF, 5'd5,  2'b01, 32'h07FF_FFFF, 0};
    vecs[11] = '{32'h0000_000F, 5'd3,  2'b00, 32'h0000_0078, 0};
    vecs[12] = '{32'h1234_5678, 5'd1,  2'b11, 32'h091A_2B3C, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_reset_in_ready", 64'(in_ready), 64'd1);

    foreach (vecs[i]) do_op(vecs[i].d, vecs[i].amt, vecs[i].mode, vecs[i].exp, vecs[i].hold);

    for (int i = 0; i < 16; i++) begin
      rd = $urandom;
      ra = 5'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      do_op(rd, ra, rm, model(rd, ra, rm), int'($urandom_range(0, 2)));
    end

    // Flush at E2 of an SLL by 20
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1; in_amt = 5'd20; in_mode = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_busy_e0", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    flush = 1'b0;
    #1 check("flush_in_ready_after", 64'(in_ready), 64'd1);

    // Flush beats an accept in IDLE
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_amt = 5'd0;
    @(posedge clk); #1;
    check("flush_blocks_accept", 64'(busy), 64'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Flush beats delivery in DONE
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hA5A5_5A5A; in_amt = 5'd0; in_mode = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_valid_before_flush", 64'(out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush_done_valid", 64'(out_valid), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);
    flush = 1'b0; out_ready = 1'b0;

    // Reset mid-RUN
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1; in_amt = 5'd31; in_mode = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_out_valid", 64'(out_valid), 64'd0);
    check("rst_run_out_data", 64'(out_data), 64'd0);
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_run_release_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-DONE
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1357_9BDF; in_amt = 5'd0; in_mode = 2'b10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_done_valid_before", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_out_valid", 64'(out_valid), 64'd0);
    check("rst_done_out_data", 64'(out_data), 64'd0);
    check("rst_done_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h8765_4321, 5'd12, 2'b11, 32'h3218_7654, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameter XLEN, default 32, sets the data width; legal values are powers of 2 from 8 to 64.
REQ-002 Parameter SHW, default 5, sets the shift-amount width; it SHALL equal log2(XLEN).
REQ-003 Parameter STEP, default 4, sets the maximum bits shifted per cycle; legal values are powers of 2 from 1 to XLEN.
REQ-004 Port `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port `in_valid`, input, 1 bit: request present.
REQ-007 Port `in_ready`, output, 1 bit: block can accept a request.
REQ-008 Port `in_data`, input, XLEN bits: operand.
REQ-009 Port `in_amt`, input, SHW bits: shift amount, 0 to XLEN-1.
REQ-010 Port `in_mode`, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-011 Port `flush`, input, 1 bit: synchronous abort.
REQ-012 Port `out_valid`, output, 1 bit: result present.
REQ-013 Port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-014 Port `out_data`, output, XLEN bits: result.
REQ-015 Port `busy`, output, 1 bit: high in RUN or DONE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE. `in_ready` = (state == IDLE) && !flush.
REQ-017 Accept = `in_valid` && `in_ready` at a rising edge (E0). On accept the block SHALL:
- latch `in_data` into the working register;
- latch `in_amt` into the remaining counter `rem`;
- latch `in_mode`;
- for SRA, latch the sign bit `in_data[XLEN-1]`.
REQ-018 On accept, the next state SHALL be DONE if `in_amt` == 0, otherwise RUN.
REQ-019 In RUN, each edge SHALL shift the working register by k = min(STEP, rem) and set rem = rem - k; when rem reaches 0, the next state SHALL be DONE.
REQ-020 Fill rules per mode:
- SLL fills LSBs with 0.
- SRL fills MSBs with 0.
- SRA fills MSBs with the latched sign bit.
- ROR moves the bits shifted out of the LSB end into the MSB end (rotate right).
REQ-021 Latency: `out_valid` SHALL rise immediately after edge E_n, where n = ceil(in_amt / STEP). Examples: amt=0 gives n=0; amt=31 with STEP=4 gives n=8.
REQ-022 In DONE, `out_valid` = 1 and `out_data` = the final working register, held stable until `out_ready` = 1 at an edge; the next state is then IDLE.
REQ-023 No new request SHALL be accepted in the same cycle that a result is delivered; the minimum request-to-request spacing is n+2 edges.
REQ-024 `out_data` SHALL be 0 whenever `out_valid` = 0.
REQ-025 `in_valid` while busy SHALL be ignored, with no latching and no side effect.
REQ-026 `flush` = 1 at an edge SHALL force IDLE from any state and discard the in-flight result; `out_valid` = 0 after that edge.
REQ-027 `flush` SHALL take priority over accept and over result delivery.
REQ-028 Operand, mode and amount changes on the inputs after accept SHALL NOT affect the in-flight result.
REQ-029 `rem` SHALL be SHW bits wide; k never exceeds rem, so rem never underflows.

Reset
REQ-030 Whenever `rst_n` = 0, asynchronously and regardless of clock:
- state = IDLE;
- working register, rem, latched mode and sign = 0;
- `out_valid` = 0, `out_data` = 0, `busy` = 0;
- `in_ready` = 0.
REQ-031 After `rst_n` deasserts, `in_ready` SHALL be 1 from the first cycle and the first edge SHALL be able to accept a request.
REQ-032 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation with no output pulse.

Verification (XLEN=32, STEP=4)
REQ-033 SLL with in_data 0x00000001, amt 31 SHALL produce `out_data` 0x80000000, with `out_valid` rising after E8 and `busy` high E0..delivery.
REQ-034 SRA with in_data 0x80000000, amt 4 SHALL produce 0xF8000000 after E1; SRL with the same operands SHALL produce 0x08000000.
REQ-035 ROR with in_data 0x000000F1, amt 4 SHALL produce 0x1000000F; ROR with 0x12345678, amt 8 SHALL produce 0x78123456 after E2.
REQ-036 in_data 0xDEADBEEF with amt 0 SHALL give `out_valid` after E0 with `out_data` 0xDEADBEEF; a second `in_valid` pulse while busy SHALL be ignored.
REQ-037 With `out_ready` held 0 for 3 cycles in DONE, `out_data` and `out_valid` SHALL stay stable and `in_ready` = 0; with `out_ready` = 1 the block SHALL return to IDLE on the next edge.
REQ-038 With SLL amt 20, asserting `flush` at E2 SHALL give IDLE and `out_valid` = 0 after E2; asserting `rst_n` = 0 mid-RUN on a separate run SHALL clear all outputs immediately.
